// File: rtl/instructions.sv
// -----------------------------------------------------------------------------
// instructions
//   Single-cycle execute/writeback stage for a MIPS-32 subset (add, sub, and,
//   or, slt, lw, sw, beq, j) working on a three-register window $s0..$s2
//   (register numbers 16..18) and an internal 32-word data memory.
//
// Ports
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset (clears outputs and memory)
//   i       in  32   instruction word
//   s0..s2  in  32   current values of registers 16..18
//   class3  out  2   00 R-type/unknown, 01 load/store, 10 branch, 11 jump
//   cs      out  5   {reg_write, mem_read, mem_write, branch_taken, jump}
//   os0..2  out 32   registers 16..18 after execution
//   ml      out 32   lw/sw word address, branch offset, or jump target
//   aluout  out 32   ALU result
//   All outputs are registered (one-cycle latency).
// -----------------------------------------------------------------------------
module instructions (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i,
  input  logic [31:0] s0,
  input  logic [31:0] s1,
  input  logic [31:0] s2,
  output logic [1:0]  class3,
  output logic [4:0]  cs,
  output logic [31:0] os0,
  output logic [31:0] os1,
  output logic [31:0] os2,
  output logic [31:0] ml,
  output logic [31:0] aluout
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] CLASS_ALU    = 2'b00;
  localparam logic [1:0] CLASS_MEM    = 2'b01;
  localparam logic [1:0] CLASS_BRANCH = 2'b10;
  localparam logic [1:0] CLASS_JUMP   = 2'b11;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm;

  assign op    = i[31:26];
  assign rs    = i[25:21];
  assign rt    = i[20:16];
  assign rd    = i[15:11];
  assign funct = i[5:0];
  assign imm   = {{16{i[15]}}, i[15:0]};

  // The shift-amount field has no meaning in this subset.
  logic unused_shamt;
  assign unused_shamt = ^i[10:6];

  logic [31:0] mem [32];

  // Register window read: numbers outside 16..18 read as zero.
  logic [31:0] rs_val, rt_val;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    rs_val = '0;
    rt_val = '0;
    case (rs)
      5'd16:   rs_val = s0;
      5'd17:   rs_val = s1;
      5'd18:   rs_val = s2;
      default: rs_val = '0;
    endcase
    case (rt)
      5'd16:   rt_val = s0;
      5'd17:   rt_val = s1;
      5'd18:   rt_val = s2;
      default: rt_val = '0;
    endcase
  end

  // Execute
  logic [1:0]  n_class;
  logic [4:0]  n_cs;
  logic [31:0] n_ml, n_alu, ea;
  logic        wr_en, mem_we;
  logic [4:0]  wr_num;
  logic [31:0] wr_data;
  logic [31:0] n_os0, n_os1, n_os2;

  assign ea = rs_val + imm;

  always_comb begin
    n_class = CLASS_ALU;
    n_cs    = 5'b00000;
    n_ml    = '0;
    n_alu   = '0;
    wr_en   = 1'b0;
    wr_num  = rd;
    wr_data = '0;
    mem_we  = 1'b0;
    case (op)
      OP_RTYPE: begin
        wr_en = 1'b1;
        case (funct)
          FN_ADD:  n_alu = rs_val + rt_val;
          FN_SUB:  n_alu = rs_val - rt_val;
          FN_AND:  n_alu = rs_val & rt_val;
          FN_OR:   n_alu = rs_val | rt_val;
          FN_SLT:  n_alu = {31'b0, $signed(rs_val) < $signed(rt_val)};
          default: wr_en = 1'b0;
        endcase
        n_cs    = wr_en ? 5'b10000 : 5'b00000;
        wr_data = n_alu;
      end
      OP_LW: begin
        n_class = CLASS_MEM;
        n_cs    = 5'b11000;
        n_alu   = ea;
        n_ml    = ea;
        wr_en   = 1'b1;
        wr_num  = rt;
        wr_data = mem[ea[4:0]];   // contents before this edge
      end
      OP_SW: begin
        n_class = CLASS_MEM;
        n_cs    = 5'b00100;
        n_alu   = ea;
        n_ml    = ea;
        mem_we  = 1'b1;
      end
      OP_BEQ: begin
        n_class = CLASS_BRANCH;
        n_alu   = rs_val - rt_val;
        n_ml    = {imm[29:0], 2'b00};
        n_cs    = (n_alu == '0) ? 5'b00010 : 5'b00000;
      end
      OP_J: begin
        n_class = CLASS_JUMP;
        n_cs    = 5'b00001;
        n_ml    = {4'b0, i[25:0], 2'b00};
      end
      default: ;  // NOP
    endcase

    // Writeback: only the window registers are real; other targets vanish.
    n_os0 = s0;
    n_os1 = s1;
    n_os2 = s2;
    if (wr_en) begin
      case (wr_num)
        5'd16:   n_os0 = wr_data;
        5'd17:   n_os1 = wr_data;
        5'd18:   n_os2 = wr_data;
        default: ;
      endcase
    end
  end

  // Data memory
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this memory is cleared by reset, so it is built from flops rather
    // than a RAM macro; the loop is the async clear of all 32 words.
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) mem[k] <= '0;
    end else if (mem_we) begin
      mem[ea[4:0]] <= rt_val;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      class3 <= '0;
      cs     <= '0;
      os0    <= '0;
      os1    <= '0;
      os2    <= '0;
      ml     <= '0;
      aluout <= '0;
    end else begin
      class3 <= n_class;
      cs     <= n_cs;
      os0    <= n_os0;
      os1    <= n_os1;
      os2    <= n_os2;
      ml     <= n_ml;
      aluout <= n_alu;
    end
  end

endmodule

// File: tb/tb_instructions.sv
// -----------------------------------------------------------------------------
// tb_instructions
//   Directed-vector bench for the instructions stage. The stimulus process
//   drives one instruction per cycle and pushes the hand-computed response into
//   a queue; the monitor pops and compares one entry after each rising edge.
// -----------------------------------------------------------------------------
module tb_instructions;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i, s0, s1, s2;
  logic [1:0]  class3;
  logic [4:0]  cs;
  logic [31:0] os0, os1, os2, ml, aluout;

  instructions dut (
    .clk(clk), .rst_n(rst_n), .i(i), .s0(s0), .s1(s1), .s2(s2),
    .class3(class3), .cs(cs), .os0(os0), .os1(os1), .os2(os2),
    .ml(ml), .aluout(aluout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  class3;
    logic [4:0]  cs;
    logic [31:0] os0, os1, os2, ml, aluout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive one instruction and queue its expected registered response.
  task automatic apply(input string name, input logic [31:0] instr,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [1:0] ecl, input logic [4:0] ecs,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] eml, input logic [31:0] ealu);
    exp_t e;
    @(negedge clk);
    i = instr; s0 = a; s1 = b; s2 = c;
    e.name = name; e.class3 = ecl; e.cs = ecs;
    e.os0 = e0; e.os1 = e1; e.os2 = e2; e.ml = eml; e.aluout = ealu;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".class3"}, {30'b0, class3}, 32'd0);
    check({tag, ".cs"},     {27'b0, cs},     32'd0);
    check({tag, ".os0"},    os0,             32'd0);
    check({tag, ".os1"},    os1,             32'd0);
    check({tag, ".os2"},    os2,             32'd0);
    check({tag, ".ml"},     ml,              32'd0);
    check({tag, ".aluout"}, aluout,          32'd0);
  endtask

  // Monitor
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, ".class3"}, {30'b0, class3}, {30'b0, e.class3});
      check({e.name, ".cs"},     {27'b0, cs},     {27'b0, e.cs});
      check({e.name, ".os0"},    os0,             e.os0);
      check({e.name, ".os1"},    os1,             e.os1);
      check({e.name, ".os2"},    os2,             e.os2);
      check({e.name, ".ml"},     ml,              e.ml);
      check({e.name, ".aluout"}, aluout,          e.aluout);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] NOP_I = 32'hFC000000;

  initial begin
    rst_n = 1'b0;
    i = NOP_I; s0 = 32'd4; s1 = 32'd10; s2 = 32'd20;
    repeat (2) @(posedge clk);
    #2 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    //            name        instr                                   s0            s1     s2     cls    cs         os0           os1    os2           ml            aluout
    apply("lw_after_rst", 32'h8E300020,                               4,            10,    20,    2'b01, 5'b11000,  0,            10,    20,           42,           42);
    apply("add",          32'h02328020,                               4,            10,    20,    2'b00, 5'b10000,  30,           10,    20,           0,            30);
    apply("sw",           32'hAE300020,                               4,            10,    20,    2'b01, 5'b00100,  4,            10,    20,           42,           42);
    apply("lw_after_sw",  32'h8E300020,                               99,           10,    20,    2'b01, 5'b11000,  4,            10,    20,           42,           42);
    apply("beq_nt",       32'h121100C8,                               4,            10,    20,    2'b10, 5'b00000,  4,            10,    20,           800,          32'hFFFFFFFA);
    apply("beq_t",        32'h121100C8,                               4,            4,     20,    2'b10, 5'b00010,  4,            4,     20,           800,          0);
    apply("j",            32'h080003E8,                               4,            10,    20,    2'b11, 5'b00001,  4,            10,    20,           4000,         0);
    apply("unknown_op",   NOP_I,                                      4,            10,    20,    2'b00, 5'b00000,  4,            10,    20,           0,            0);
    apply("sub",          rtype(16, 17, 18, 6'b100010),               4,            10,    20,    2'b00, 5'b10000,  4,            10,    32'hFFFFFFFA, 0,            32'hFFFFFFFA);
    apply("and",          rtype(17, 18, 17, 6'b100100),               4,            10,    20,    2'b00, 5'b10000,  4,            0,     20,           0,            0);
    apply("or",           rtype(17, 18, 18, 6'b100101),               4,            10,    20,    2'b00, 5'b10000,  4,            10,    30,           0,            30);
    apply("slt_neg",      rtype(16, 17, 18, 6'b101010),               32'hFFFFFFFB, 10,    20,    2'b00, 5'b10000,  32'hFFFFFFFB, 10,    1,            0,            1);
    apply("slt_false",    rtype(17, 16, 16, 6'b101010),               32'hFFFFFFFB, 10,    20,    2'b00, 5'b10000,  0,            10,    20,           0,            0);
    apply("bad_funct",    rtype(16, 17, 18, 6'b000000),               4,            10,    20,    2'b00, 5'b00000,  4,            10,    20,           0,            0);
    apply("add_rd8",      rtype(16, 17, 8, 6'b100000),                4,            10,    20,    2'b00, 5'b10000,  4,            10,    20,           0,            14);
    apply("sw_negimm",    itype(6'b101011, 18, 17, 16'hFFF6),         4,            10,    20,    2'b01, 5'b00100,  4,            10,    20,           10,           10);
    apply("lw_wrap",      itype(6'b100011, 16, 18, 16'h0026),         4,            10,    20,    2'b01, 5'b11000,  4,            10,    10,           42,           42);
    apply("sw_hiaddr",    itype(6'b101011, 16, 18, 16'h7FFC),         4,            10,    20,    2'b01, 5'b00100,  4,            10,    20,           32'h8000,     32'h8000);
    apply("lw_zero_rs",   itype(6'b100011, 0, 17, 16'h0000),          4,            10,    20,    2'b01, 5'b11000,  4,            20,    20,           0,            0);
    apply("beq_zero_neg", itype(6'b000100, 0, 0, 16'hFFFF),           4,            10,    20,    2'b10, 5'b00010,  4,            10,    20,           32'hFFFFFFFC, 0);
    apply("lw_rt0",       itype(6'b100011, 17, 0, 16'h0020),          4,            10,    20,    2'b01, 5'b11000,  4,            10,    20,           42,           42);

    // Let the monitor drain the last entry, then reset mid-run.
    @(negedge clk) i = NOP_I;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    // mem[10] held 10 before reset; it must read back cleared.
    apply("lw_after_mid_rst", 32'h8E300020,                           4,            10,    20,    2'b01, 5'b11000,  0,            10,    20,           42,           42);
    @(negedge clk) i = NOP_I;

    begin : drain
      int n = 0;
      while (exp_q.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
